display_source_ctrl: RTL
========================

# display_source_ctrl

Sequences the VGA source mux from the raw game-select switches. It synchronizes and debounces the select, then defers every source change to the start of vertical blanking so no frame ever shows two sources. With fading compiled in, it ramps a pixel gain down to zero, swaps the source and ramps the gain back up. It sits between the switches and the RGB source mux, ahead of the VGA timing module, and takes the VGA module's current row as its frame reference.

## Interface
- DEBOUNCE_CYCLES, 500000 — consecutive stable clocks required before a select change is accepted (10 ms at 50 MHz); minimum 1
- V_ACTIVE, 480 — first non-visible row; entering it marks a frame boundary
- FADE_STEP, 32 — gain change per frame while fading (1..255)
- RESET_SEL, 3'd0 — source selected out of reset (test bars)
- iCLK_50M  input  1  system clock, all logic on rising edge
- iRST_N  input  1  asynchronous active-low reset
- iSelect  input  3  raw, unsynchronized source select (switches)
- iCurrent_Y  input  11  current row from VGA timing
- oSelect  output  3  registered mux select; changes only in vertical blanking
- oGain  output  8  registered pixel gain, 8'hFF = unity; fixed at 8'hFF when DISPLAY_FADE_EN is undefined
- oBusy  output  1  high whenever the FSM is not in IDLE
- oFrameTick  output  1  one-cycle pulse on entry to vertical blanking

## Operation
- Input path: 2-flop synchronizer on iSelect, then the debouncer. The debouncer counter clears on any change of the synchronized value. After DEBOUNCE_CYCLES consecutive equal samples, that value loads into `accepted`.
- Frame tick: vb = (iCurrent_Y >= V_ACTIVE), registered as vb_q. oFrameTick = vb & ~vb_q, also registered.
- FSM states: IDLE, WAIT_VB, FADE_OUT, SWAP, FADE_IN.
  - IDLE: if accepted != oSelect, go to WAIT_VB.
  - WAIT_VB: on a frame tick, go to FADE_OUT (fade build) or SWAP (no fade).
  - FADE_OUT: on each tick, gain = sat0(gain − FADE_STEP). When gain reaches 0, go to SWAP.
  - SWAP: one cycle. oSelect <= accepted. Next state is FADE_IN (fade build) or IDLE.
  - FADE_IN: on each tick, gain = sat255(gain + FADE_STEP). When gain reaches 8'hFF, go to IDLE.
- Gain arithmetic uses 9 bits internally and saturates to 0 and 8'hFF. No wrap is allowed.
- `accepted` is sampled at SWAP, so the latest debounced value wins. If accepted equals oSelect at SWAP, the swap is a no-op and fade-in still completes.
- On return to IDLE, a still-differing accepted value starts a new cycle immediately.
- Reset mid-operation: all state returns to reset values immediately. No fade resumes.
- iSelect glitches shorter than DEBOUNCE_CYCLES are never accepted.

## Timing
- Reset values: oSelect = RESET_SEL, oGain = 8'hFF, oBusy = 0, oFrameTick = 0, accepted = RESET_SEL, state = IDLE.
- Select latency: 2 sync cycles + DEBOUNCE_CYCLES cycles to update accepted, then 1 cycle to leave IDLE.
- Frame tick rises 1 cycle after iCurrent_Y first reaches V_ACTIVE.
- No-fade build: oSelect updates 2 cycles after the tick (WAIT_VB→SWAP, then the SWAP register). The result is well inside blanking.
- Fade build: the gain changes on the cycle after each tick. The swap happens at most once per frame, in the blanking period of the frame where the gain reaches 0.
- A frame tick that arrives while in SWAP is not consumed by the FADE_IN of the same swap.

## Configuration
- DISPLAY_FADE_EN defined: FADE_OUT and FADE_IN states and the gain register are built, as described above.
- DISPLAY_FADE_EN undefined: the fade states and gain register are not built. oGain is tied to 8'hFF and FADE_STEP is unused.

## Structure
- display_pkg holds:
  - the state enum (ctrl_state_t)
  - NUM_SOURCES = 8
  - H_ACTIVE = 640 and V_ACTIVE_DEFAULT = 480
  - GAIN_FULL = 8'hFF
- One sub-module, select_debouncer, parameterized by width and DEBOUNCE_CYCLES. It contains the synchronizer, counter and accepted register.
- The top instantiates display_source_ctrl and applies oGain to the mux output.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4, FADE_STEP = 64 and a row counter model unless stated otherwise.
- Reset, then hold iSelect = 0 → oSelect = 0, oGain = 8'hFF, oBusy = 0 across 3 frames.
- Fade build: step iSelect 0→3 → accepted = 3 after 6 cycles. oGain falls over 4 ticks: 191, 127, 63, 0. oSelect becomes 3 in that frame's blanking. oGain then rises over 4 ticks: 64, 128, 192, 255. oBusy drops afterwards.
- Pulse iSelect to 5 for 3 cycles, then return to 0 → accepted stays 0, oBusy stays 0.
- Change iSelect 0→1 during FADE_OUT, then 1→2 before gain reaches 0 → the swap yields oSelect = 2. There is only one fade cycle.
- No-fade build: step iSelect 0→6 mid-frame → oSelect stays 0 until the frame tick, then becomes 6 two cycles later. oGain stays 8'hFF.
- Assert iRST_N = 0 while in FADE_IN with gain 128 → oGain = 8'hFF and oSelect = RESET_SEL immediately, without waiting for a clock.

Source files
------------

// File: rtl/display_pkg.sv
// Shared state type and constants for the display source controller.
package display_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitVb,
    StFadeOut,
    StSwap,
    StFadeIn
  } ctrl_state_t;

  localparam int unsigned NUM_SOURCES      = 8;
  localparam int unsigned SEL_W            = $clog2(NUM_SOURCES);
  localparam int unsigned H_ACTIVE         = 640;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;
  localparam logic [7:0]  GAIN_FULL        = 8'hFF;

endpackage

// File: rtl/select_debouncer.sv
// Two-flop synchronizer plus stability counter; a value is accepted only after
// DEBOUNCE_CYCLES consecutive identical synchronized samples.
module select_debouncer #(
  parameter int unsigned      WIDTH           = 3,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] accepted
);

  localparam int unsigned    CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

  logic [WIDTH-1:0] sync1_q, sync2_q, cand_q, accepted_q;
  logic [CntW-1:0]  cnt_q, cnt_d;

  // cnt_d is the number of consecutive samples equal to sync2_q, saturating.
  always_comb begin
    cnt_d = cnt_q;
    if (sync2_q != cand_q) begin
      cnt_d = CntW'(1);
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= RESET_VAL;
      sync2_q    <= RESET_VAL;
      cand_q     <= RESET_VAL;
      cnt_q      <= '0;
      accepted_q <= RESET_VAL;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      cnt_q   <= cnt_d;
      if (cnt_d == CntMax) begin
        accepted_q <= sync2_q;
      end
    end
  end

  assign accepted = accepted_q;

endmodule

// File: rtl/display_source_ctrl.sv
// Defers VGA source changes to vertical blanking, optionally fading the gain around the swap.
// Fading is built only when DISPLAY_FADE_EN is defined; otherwise oGain is fixed at unity.
module display_source_ctrl
  import display_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned V_ACTIVE        = V_ACTIVE_DEFAULT,
  parameter int unsigned FADE_STEP       = 32,
  parameter logic [2:0]  RESET_SEL       = 3'd0
) (
  input  logic        iCLK_50M,
  input  logic        iRST_N,
  input  logic [2:0]  iSelect,
  input  logic [10:0] iCurrent_Y,
  output logic [2:0]  oSelect,
  output logic [7:0]  oGain,
  output logic        oBusy,
  output logic        oFrameTick
);

`ifdef DISPLAY_FADE_EN
  localparam bit FadeBuilt = 1'b1;
`else
  localparam bit FadeBuilt = 1'b0;
`endif

  logic [2:0]  accepted;
  logic        vb, vb_q, tick_q;
  ctrl_state_t state_q, state_d;
  logic [2:0]  sel_q, sel_d;

  select_debouncer #(
    .WIDTH          (SEL_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RESET_VAL      (RESET_SEL)
  ) u_debouncer (
    .clk     (iCLK_50M),
    .rst_n   (iRST_N),
    .raw     (iSelect),
    .accepted(accepted)
  );

  assign vb = ({21'd0, iCurrent_Y} >= V_ACTIVE);

`ifdef DISPLAY_FADE_EN
  localparam logic [8:0] Step9 = 9'(FADE_STEP);

  logic [7:0] gain_q, gain_d, gain_dn, gain_up;
  logic [8:0] dn_wide, up_wide;

  // Ninth bit flags borrow/carry so the gain saturates instead of wrapping.
  assign dn_wide = {1'b0, gain_q} - Step9;
  assign up_wide = {1'b0, gain_q} + Step9;
  assign gain_dn = dn_wide[8] ? 8'd0 : dn_wide[7:0];
  assign gain_up = up_wide[8] ? GAIN_FULL : up_wide[7:0];

  always_ff @(posedge iCLK_50M or negedge iRST_N) begin
    if (!iRST_N) begin
      gain_q <= GAIN_FULL;
    end else begin
      gain_q <= gain_d;
    end
  end

  assign oGain = gain_q;
`else
  logic unused_fade_step;
  assign unused_fade_step = (FADE_STEP != 0);
  assign oGain = GAIN_FULL;
`endif

  always_ff @(posedge iCLK_50M or negedge iRST_N) begin
    if (!iRST_N) begin
      vb_q    <= 1'b0;
      tick_q  <= 1'b0;
      state_q <= StIdle;
      sel_q   <= RESET_SEL;
    end else begin
      vb_q    <= vb;
      tick_q  <= vb & ~vb_q;
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
`ifdef DISPLAY_FADE_EN
    gain_d  = gain_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accepted != sel_q) state_d = StWaitVb;
      end
      StWaitVb: begin
        if (tick_q) state_d = FadeBuilt ? StFadeOut : StSwap;
      end
`ifdef DISPLAY_FADE_EN
      StFadeOut: begin
        if (tick_q) begin
          gain_d = gain_dn;
          if (gain_dn == 8'd0) state_d = StSwap;
        end
      end
`endif
      StSwap: begin
        // Sampled here so the most recent debounced choice wins.
        sel_d   = accepted;
        state_d = FadeBuilt ? StFadeIn : StIdle;
      end
`ifdef DISPLAY_FADE_EN
      StFadeIn: begin
        if (tick_q) begin
          gain_d = gain_up;
          if (gain_up == GAIN_FULL) state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  assign oSelect    = sel_q;
  assign oBusy      = (state_q != StIdle);
  assign oFrameTick = tick_q;

endmodule
